// File: rtl/seg_scan_mux_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_mux_pkg
//  Purpose  : Shared constants, types and helpers for the seven-segment
//             scan multiplexer.
//  Revision : 1.0  initial release
// ============================================================================
package seg_scan_mux_pkg;

  localparam int         DIGITS           = 4;
  localparam logic [6:0] SEG_OFF          = 7'h7F;
  localparam logic [3:0] AN_OFF           = 4'hF;
  localparam logic [6:0] ZERO_PAT_DEFAULT = 7'b1000000;

  // Digit slot currently being scanned; digit 3 is the most significant.
  typedef enum logic [1:0] {
    DIG_0 = 2'd0,
    DIG_1 = 2'd1,
    DIG_2 = 2'd2,
    DIG_3 = 2'd3
  } digit_e;

  // Leading-zero mask: a digit is suppressed only when it and every more
  // significant digit show zero. Digit 0 always stays visible.
  function automatic logic [DIGITS-1:0] lz_blank_mask(input logic [DIGITS-1:0] is_zero,
                                                      input logic              blz);
    logic [DIGITS-1:0] mask;
    mask    = '0;
    mask[3] = blz & is_zero[3];
    mask[2] = mask[3] & is_zero[2];
    mask[1] = mask[2] & is_zero[1];
    return mask;
  endfunction

  // Active-low one-cold anode enable for a digit slot.
  function automatic logic [DIGITS-1:0] anode_sel(input digit_e d);
    return ~(4'b0001 << d);
  endfunction

endpackage
`default_nettype wire

// File: rtl/seg_scan_mux_if.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_mux_if
//  Purpose  : Digit-path inputs and display-bus outputs of the scan mux.
//             master = upstream digit path / display, slave = scan mux.
//  Revision : 1.0  initial release
// ============================================================================
interface seg_scan_mux_if;

  // Segment buses, bit i belongs to digit i, active-low
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] c;
  logic [3:0] d;
  logic [3:0] e;
  logic [3:0] f;
  logic [3:0] g;
  logic [3:0] dp;      // decimal point request, active-high
  logic       blz;     // leading-zero blanking enable
  logic [3:0] bright;  // lit phases per slot
  logic       blank;   // force display dark

  // Display side
  logic [6:0] seg_out; // {g,f,e,d,c,b,a}, active-low
  logic       dp_n;
  logic [3:0] an_n;
  logic       frame_start;

  modport master (
    output a, b, c, d, e, f, g, dp, blz, bright, blank,
    input  seg_out, dp_n, an_n, frame_start
  );

  modport slave (
    input  a, b, c, d, e, f, g, dp, blz, bright, blank,
    output seg_out, dp_n, an_n, frame_start
  );

endinterface
`default_nettype wire

// File: rtl/seg_scan_mux_scan_tick_gen.sv
`default_nettype none
// ============================================================================
//  Module   : scan_tick_gen
//  Purpose  : Refresh prescaler. Counts 0..REFRESH_DIV-1 and flags the last
//             count as a one-clock scan tick.
//  Revision : 1.0  initial release
// ============================================================================
module scan_tick_gen #(
  parameter int REFRESH_DIV = 1000
) (
  input  wire  clock,
  input  wire  reset_n,
  output logic tick
);

  localparam int             CNT_W    = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Tick on the terminal count, then wrap to zero.
  always_comb begin
    tick  = (cnt_q == CNT_LAST);
    cnt_d = tick ? '0 : cnt_q + 1'b1;
  end

  // Prescaler register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : seg_scan_mux
//  Purpose  : Time-multiplexed 4-digit seven-segment driver with refresh
//             prescaling, frame-coherent snapshot, leading-zero blanking,
//             decimal points, per-slot dead time and PWM brightness.
//  Revision : 1.0  initial release
// ============================================================================
module seg_scan_mux
  import seg_scan_mux_pkg::*;
#(
  parameter int         REFRESH_DIV = 1000,
  parameter int         PHASES      = 16,
  parameter logic [6:0] ZERO_PAT    = ZERO_PAT_DEFAULT
) (
  input wire            clock,
  input wire            reset_n,
  seg_scan_mux_if.slave bus
);

  localparam int            PH_W    = (PHASES > 2) ? $clog2(PHASES) : 1;
  localparam int            CMP_W   = (PH_W > 4) ? PH_W : 4;
  localparam logic [PH_W-1:0] PH_LAST = PH_W'(PHASES - 1);

  logic tick;

  // Scan state
  logic [PH_W-1:0] phase_q, phase_d;
  digit_e          digit_q, digit_d;

  // Frame snapshot
  logic [6:0]        snap_pat_q [DIGITS];
  logic [6:0]        snap_pat_d [DIGITS];
  logic [DIGITS-1:0] snap_dp_q, snap_dp_d;
  logic [3:0]        snap_bright_q, snap_bright_d;
  logic              snap_blz_q, snap_blz_d;

  // Registered outputs
  logic [6:0]        seg_q, seg_d;
  logic              dp_n_q, dp_n_d;
  logic [DIGITS-1:0] an_n_q, an_n_d;
  logic              frame_start_q, frame_start_d;

  // Decode helpers
  logic [6:0]        in_pat [DIGITS];
  logic [DIGITS-1:0] is_zero;
  logic [DIGITS-1:0] blanked;
  logic              phase_last;
  logic              frame_wrap;
  logic              lit;

  scan_tick_gen #(
    .REFRESH_DIV (REFRESH_DIV)
  ) u_tick (
    .clock   (clock),
    .reset_n (reset_n),
    .tick    (tick)
  );

  // Regroup the per-segment buses into one pattern per digit.
  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    assign in_pat[i]  = {bus.g[i], bus.f[i], bus.e[i], bus.d[i],
                         bus.c[i], bus.b[i], bus.a[i]};
    assign is_zero[i] = (snap_pat_q[i] == ZERO_PAT);
  end

  // Phase/digit advance; the wrap out of digit 3 starts a new frame.
  always_comb begin
    phase_d    = phase_q;
    digit_d    = digit_q;
    phase_last = (phase_q == PH_LAST);
    frame_wrap = tick && phase_last && (digit_q == DIG_3);
    if (tick) begin
      if (phase_last) begin
        phase_d = '0;
        digit_d = digit_e'(digit_q + 2'd1);
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  // Capture the whole display state once per frame so a frame never tears.
  always_comb begin
    snap_pat_d    = snap_pat_q;
    snap_dp_d     = snap_dp_q;
    snap_bright_d = snap_bright_q;
    snap_blz_d    = snap_blz_q;
    if (frame_wrap) begin
      for (int i = 0; i < DIGITS; i++) begin
        snap_pat_d[i] = in_pat[i];
      end
      snap_dp_d     = bus.dp;
      snap_bright_d = bus.bright;
      snap_blz_d    = bus.blz;
    end
  end

  // Decide whether the current slot is lit and select the output values.
  always_comb begin
    blanked       = lz_blank_mask(is_zero, snap_blz_q);
    lit           = (phase_q != '0)
                 && (CMP_W'(phase_q) <= CMP_W'(snap_bright_q))
                 && !bus.blank
                 && !blanked[digit_q];
    seg_d         = SEG_OFF;
    an_n_d        = AN_OFF;
    dp_n_d        = 1'b1;
    frame_start_d = frame_wrap;
    if (lit) begin
      seg_d  = snap_pat_q[digit_q];
      an_n_d = anode_sel(digit_q);
      dp_n_d = ~snap_dp_q[digit_q];
    end
  end

  // State, snapshot and output registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      phase_q       <= '0;
      digit_q       <= DIG_0;
      for (int i = 0; i < DIGITS; i++) begin
        snap_pat_q[i] <= SEG_OFF;
      end
      snap_dp_q     <= '0;
      snap_bright_q <= '0;
      snap_blz_q    <= 1'b0;
      seg_q         <= SEG_OFF;
      dp_n_q        <= 1'b1;
      an_n_q        <= AN_OFF;
      frame_start_q <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      digit_q       <= digit_d;
      snap_pat_q    <= snap_pat_d;
      snap_dp_q     <= snap_dp_d;
      snap_bright_q <= snap_bright_d;
      snap_blz_q    <= snap_blz_d;
      seg_q         <= seg_d;
      dp_n_q        <= dp_n_d;
      an_n_q        <= an_n_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign bus.seg_out     = seg_q;
  assign bus.dp_n        = dp_n_q;
  assign bus.an_n        = an_n_q;
  assign bus.frame_start = frame_start_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
//  Module   : tb_seg_scan_mux
//  Purpose  : Self-checking bench for seg_scan_mux with a timeline-based
//             reference model (state derived from clocks since reset).
//  Revision : 1.0  initial release
// ============================================================================
module tb_seg_scan_mux;

  localparam int DIV   = 4;
  localparam int PH    = 16;
  localparam int FRAME = DIV * PH * 4;

  logic clock   = 1'b0;
  logic reset_n = 1'b0;

  seg_scan_mux_if bus ();

  seg_scan_mux #(
    .REFRESH_DIV (DIV),
    .PHASES      (PH),
    .ZERO_PAT    (7'b1000000)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model state
  int         m_t;
  logic [6:0] m_pat [4];
  logic [3:0] m_dp;
  logic [3:0] m_br;
  logic       m_blz;
  logic [6:0] exp_seg;
  logic [3:0] exp_an;
  logic       exp_dpn;
  logic       exp_fs;

  int lit_cnt [4];

  function automatic logic [6:0] seg_code(input int n);
    case (n)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      default: return 7'b0010000;
    endcase
  endfunction

  // A digit is hidden when it and all more significant digits read zero.
  function automatic logic m_blanked(input int dg);
    if (!m_blz || dg == 0) return 1'b0;
    for (int j = dg; j < 4; j++)
      if (m_pat[j] != 7'b1000000) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_t = 0;
    for (int j = 0; j < 4; j++) m_pat[j] = 7'h7F;
    m_dp    = 4'h0;
    m_br    = 4'h0;
    m_blz   = 1'b0;
    exp_seg = 7'h7F;
    exp_an  = 4'hF;
    exp_dpn = 1'b1;
    exp_fs  = 1'b0;
  endtask

  // Called right after a rising edge: outputs follow the state that held
  // before the edge; m_t counts edges since reset release.
  task automatic model_step();
    int   k, ph, dg;
    logic lit;
    k   = m_t / DIV;
    ph  = k % PH;
    dg  = (k / PH) % 4;
    lit = (ph != 0) && (ph <= int'(m_br)) && !bus.blank && !m_blanked(dg);
    exp_an  = lit ? ~(4'b0001 << dg) : 4'hF;
    exp_seg = lit ? m_pat[dg] : 7'h7F;
    exp_dpn = lit ? ~m_dp[dg] : 1'b1;
    m_t++;
    exp_fs = ((m_t % DIV) == 0) && (((m_t / DIV) % (4 * PH)) == 0);
    if (exp_fs) begin
      for (int j = 0; j < 4; j++)
        m_pat[j] = {bus.g[j], bus.f[j], bus.e[j], bus.d[j], bus.c[j], bus.b[j], bus.a[j]};
      m_dp  = bus.dp;
      m_br  = bus.bright;
      m_blz = bus.blz;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_outputs();
    chk("seg_out", bus.seg_out, exp_seg);
    chk("an_n", bus.an_n, exp_an);
    chk("dp_n", bus.dp_n, exp_dpn);
    chk("frame_start", bus.frame_start, exp_fs);
    chk("an_single", ($countones(~bus.an_n) <= 1), 1);
  endtask

  task automatic cycle();
    @(posedge clock);
    model_step();
    @(negedge clock);
    check_outputs();
  endtask

  task automatic set_pats(input logic [6:0] p3, input logic [6:0] p2,
                          input logic [6:0] p1, input logic [6:0] p0);
    logic [6:0] p [4];
    p[0] = p0; p[1] = p1; p[2] = p2; p[3] = p3;
    for (int j = 0; j < 4; j++)
      {bus.g[j], bus.f[j], bus.e[j], bus.d[j], bus.c[j], bus.b[j], bus.a[j]} = p[j];
  endtask

  task automatic set_digits(input int d3, input int d2, input int d1, input int d0);
    set_pats(seg_code(d3), seg_code(d2), seg_code(d1), seg_code(d0));
  endtask

  task automatic wait_frame();
    for (int n = 0; n < FRAME + 8; n++) begin
      cycle();
      if (exp_fs) return;
    end
    checks++;
    errors++;
    $error("FAIL wait_frame observed=timeout expected=frame_start");
  endtask

  // Run one full frame and count lit clocks per anode.
  task automatic frame_counts();
    for (int j = 0; j < 4; j++) lit_cnt[j] = 0;
    repeat (FRAME) begin
      cycle();
      for (int j = 0; j < 4; j++)
        if (bus.an_n == ~(4'b0001 << j)) lit_cnt[j]++;
    end
  endtask

  task automatic measure_first_frame(input string tag);
    int fs_at;
    int saw_lit;
    fs_at   = -1;
    saw_lit = 0;
    for (int i = 1; i <= FRAME + 20; i++) begin
      cycle();
      if (bus.an_n !== 4'hF) saw_lit = 1;
      if (bus.frame_start === 1'b1) begin
        fs_at = i;
        break;
      end
    end
    chk(tag, fs_at, FRAME);
    chk("dark_before_frame", saw_lit, 0);
  endtask

  initial begin
    logic [6:0] old_pat [4];

    bus.a = 4'hF; bus.b = 4'hF; bus.c = 4'hF; bus.d = 4'hF;
    bus.e = 4'hF; bus.f = 4'hF; bus.g = 4'hF;
    bus.dp = 4'h0; bus.blz = 1'b0; bus.bright = 4'd0; bus.blank = 1'b0;
    model_reset();

    // Reset values and first frame timing
    repeat (3) @(negedge clock);
    check_outputs();
    set_digits(1, 2, 3, 4);
    bus.bright = 4'd15;
    reset_n = 1'b1;
    measure_first_frame("first_frame_start");

    // Full brightness, no blanking: 60 lit clocks per slot
    frame_counts();
    for (int j = 0; j < 4; j++) chk("bright15_lit", lit_cnt[j], 60);

    // Leading-zero blanking
    set_digits(0, 0, 0, 5);
    bus.blz = 1'b1;
    wait_frame();
    frame_counts();
    chk("blz_d0", lit_cnt[0], 60);
    for (int j = 1; j < 4; j++) chk("blz_hidden", lit_cnt[j], 0);
    bus.blz = 1'b0;
    wait_frame();
    frame_counts();
    for (int j = 0; j < 4; j++) chk("noblz_lit", lit_cnt[j], 60);

    // Mid-frame input change must not reach the display until next frame
    set_digits(1, 2, 3, 4);
    wait_frame();
    repeat (100) cycle();
    for (int j = 0; j < 4; j++) old_pat[j] = seg_code(4 - j);
    set_digits(9, 8, 7, 6);
    for (int i = 0; i < FRAME - 100; i++) begin
      cycle();
      for (int j = 0; j < 4; j++)
        if (bus.an_n == ~(4'b0001 << j)) chk("hold_seg", bus.seg_out, old_pat[j]);
    end
    chk("frame_edge", bus.frame_start, 1);
    repeat (10) cycle();
    chk("new_seg", bus.seg_out, seg_code(6));

    // PWM brightness and decimal points
    bus.bright = 4'd3;
    bus.dp     = 4'b0101;
    wait_frame();
    frame_counts();
    for (int j = 0; j < 4; j++) chk("bright3_lit", lit_cnt[j], 12);
    bus.bright = 4'd0;
    wait_frame();
    frame_counts();
    for (int j = 0; j < 4; j++) chk("bright0_lit", lit_cnt[j], 0);

    // Blank pulse mid-slot, then resume at the same digit/phase
    bus.bright = 4'd15;
    wait_frame();
    repeat (FRAME / 4 + 32) cycle();
    chk("pre_blank", bus.an_n, 4'hD);
    bus.blank = 1'b1;
    cycle();
    chk("blank_dark", bus.an_n, 4'hF);
    bus.blank = 1'b0;
    cycle();
    cycle();
    chk("blank_resume", bus.an_n, 4'hD);

    // Asynchronous reset mid-frame
    repeat (50) cycle();
    #2 reset_n = 1'b0;
    #1;
    chk("rst_seg", bus.seg_out, 7'h7F);
    chk("rst_an", bus.an_n, 4'hF);
    chk("rst_dp", bus.dp_n, 1'b1);
    chk("rst_fs", bus.frame_start, 1'b0);
    model_reset();
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    measure_first_frame("rerun_frame_start");

    // Randomized frames against the model
    for (int fr = 0; fr < 6; fr++) begin
      logic [6:0] rp [4];
      for (int j = 0; j < 4; j++) begin
        if ($urandom_range(0, 1) == 0) rp[j] = seg_code(0);
        else if ($urandom_range(0, 1) == 0) rp[j] = seg_code(int'($urandom_range(0, 9)));
        else rp[j] = 7'($urandom);
      end
      set_pats(rp[3], rp[2], rp[1], rp[0]);
      bus.dp     = 4'($urandom);
      bus.bright = 4'($urandom);
      bus.blz    = 1'($urandom);
      repeat (FRAME + int'($urandom_range(0, 200))) begin
        bus.blank = ($urandom_range(0, 19) == 0);
        cycle();
      end
      bus.blank = 1'b0;
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
